uart_tx_sched: RTL

- Round-robin scheduler that shares one UART transmitter (send / tx_data interface, 8N1) among NREQ byte requesters.
- Sits between producer blocks (status reporter, debug dump, loopback echo, command responder) and the UART.
- Grants one byte at a time, issues a one-cycle send strobe, then blocks further sends for a programmed frame time, because the UART exposes no busy flag.

---
 rtl/uart_tx_sched_if.sv | 45 ++++
 rtl/uart_tx_sched.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched_if.sv
// ---------------------------------------------------------------------------
// uart_tx_sched_if
//   Bundles the requester-side byte requests and the UART-side send/data
//   outputs of the UART transmit scheduler.
//
//   Signals:
//     req          NREQ   per-requester level request (data valid while high)
//     req_data     8*NREQ byte for requester i on bits [8i+7:8i]
//     gnt          NREQ   one-hot, one-cycle grant pulse
//     busy         1      frame window in progress
//     uart_send    1      one-cycle send strobe to the UART
//     uart_tx_data 8      byte to the UART, held stable between grants
//
//   Modports:
//     master : the requester/system side (drives req, req_data)
//     slave  : the scheduler (drives gnt, busy, uart_send, uart_tx_data)
// ---------------------------------------------------------------------------
interface uart_tx_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              uart_send;
    logic [7:0]        uart_tx_data;

    modport master (
        output req,
        output req_data,
        input  gnt,
        input  busy,
        input  uart_send,
        input  uart_tx_data
    );

    modport slave (
        input  req,
        input  req_data,
        output gnt,
        output busy,
        output uart_send,
        output uart_tx_data
    );
endinterface

// File: rtl/uart_tx_sched.sv
// ---------------------------------------------------------------------------
// uart_tx_sched
//   Round-robin scheduler sharing one 8N1 UART transmitter among NREQ byte
//   requesters. One byte is granted at a time: a one-cycle send strobe is
//   issued, then further sends are blocked for FRAME_CYCLES cycles because
//   the UART has no busy flag of its own.
//
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   asynchronous, active-high reset
//     bus  slave modport of uart_tx_sched_if (req/req_data in,
//          gnt/busy/uart_send/uart_tx_data out, all outputs registered)
//
//   Parameters:
//     NREQ          number of requesters (2..8)
//     FRAME_CYCLES  clk cycles reserved per byte after a send
//     CNT_WIDTH     frame counter width, 2**CNT_WIDTH > FRAME_CYCLES
//
//   Build option:
//     UART_SCHED_PRIO0_EN  when defined, requester 0 has strict priority and
//                          the remaining requesters rotate among themselves.
//                          Undefined: pure round-robin over all requesters.
// ---------------------------------------------------------------------------
module uart_tx_sched #(
    parameter int NREQ         = 4,
    parameter int FRAME_CYCLES = 12600,
    parameter int CNT_WIDTH    = 14
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_sched_if.slave   bus
);
    localparam int LAST_W = $clog2(NREQ);

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [LAST_W-1:0]    last, last_nxt;
    logic [NREQ-1:0]      gnt_q, gnt_nxt;
    logic                 send_q, send_nxt;
    logic                 busy_q, busy_nxt;
    logic [7:0]           data_q, data_nxt;

    logic [LAST_W-1:0]    win;
    logic                 win_vld;
    logic [LAST_W-1:0]    idx;

    // Winner search: first set request scanning last+1, last+2, ... mod NREQ.
    // The pointer starts at NREQ-1 after reset so requester 0 is first.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = LAST_W'((int'(last) + k) % NREQ);
`ifdef UART_SCHED_PRIO0_EN
            // Requester 0 is handled by the priority override below.
            if (!win_vld && bus.req[idx] && (idx != '0)) begin
`else
            if (!win_vld && bus.req[idx]) begin
`endif
                win     = idx;
                win_vld = 1'b1;
            end
        end
`ifdef UART_SCHED_PRIO0_EN
        if (bus.req[0]) begin
            win     = '0;
            win_vld = 1'b1;
        end
`endif
    end

    // Next-state and next-output logic; every output is registered below,
    // so there is no combinational path from req to gnt or uart_send.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        gnt_nxt   = '0;
        send_nxt  = 1'b0;
        busy_nxt  = busy_q;
        data_nxt  = data_q;   // byte held through WAIT and IDLE
        case (state)
            IDLE: begin
                if (win_vld) begin
                    gnt_nxt[win] = 1'b1;
                    send_nxt     = 1'b1;
                    data_nxt     = bus.req_data[int'(win)*8 +: 8];
`ifdef UART_SCHED_PRIO0_EN
                    // Priority wins by requester 0 do not disturb the rotation.
                    if (win != '0) begin
                        last_nxt = win;
                    end
`else
                    last_nxt = win;
`endif
                    cnt_nxt   = CNT_WIDTH'(FRAME_CYCLES - 1);
                    busy_nxt  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Counts FRAME_CYCLES-1 down to 0: exactly FRAME_CYCLES cycles.
                if (cnt == '0) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            last   <= LAST_W'(NREQ - 1);
            gnt_q  <= '0;
            send_q <= 1'b0;
            busy_q <= 1'b0;
            data_q <= 8'h00;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            last   <= last_nxt;
            gnt_q  <= gnt_nxt;
            send_q <= send_nxt;
            busy_q <= busy_nxt;
            data_q <= data_nxt;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.uart_send    = send_q;
    assign bus.busy         = busy_q;
    assign bus.uart_tx_data = data_q;

endmodule
